// File: rtl/picobello_mcast_unroller.sv
// Multicast-to-unicast expander: walks every X/Y coordinate combination left
// don't-care by the mask and issues one back-pressured unicast beat per destination.
module picobello_mcast_unroller #(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned XOffset      = 20,
  parameter int unsigned XLen         = 3,
  parameter int unsigned YOffset      = 18,
  parameter int unsigned YLen         = 2,
  parameter int unsigned PayloadWidth = 8,
  localparam int unsigned IdxWidth    = XLen + YLen + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [AddrWidth-1:0]    in_addr_i,
  input  logic [AddrWidth-1:0]    in_mask_i,
  input  logic [PayloadWidth-1:0] in_payload_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [AddrWidth-1:0]    out_addr_o,
  output logic [PayloadWidth-1:0] out_payload_o,
  output logic                    out_last_o,
  output logic [IdxWidth-1:0]     out_idx_o,
  output logic                    busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // out_valid_o rises it stays high, with all out_* fields stable, until taken.

  function automatic logic [AddrWidth-1:0] field_mask();
    logic [AddrWidth-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < AddrWidth; i++) begin
      if ((i >= XOffset && i < XOffset + XLen) || (i >= YOffset && i < YOffset + YLen)) begin
        f[i] = 1'b1;
      end
    end
    return f;
  endfunction

  localparam logic [AddrWidth-1:0] FieldMask = field_mask();

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e                  state_q;
  logic [AddrWidth-1:0]    base_q;
  logic [AddrWidth-1:0]    mask_q;
  logic [AddrWidth-1:0]    cur_q;
  logic [AddrWidth-1:0]    cur_d;
  logic [IdxWidth-1:0]     idx_q;
  logic [PayloadWidth-1:0] payload_q;
  logic [AddrWidth-1:0]    in_mask_eff;
  logic                    issuing;
  logic                    last_beat;
  logic                    out_hs;
  logic                    accept;

  assign in_mask_eff = in_mask_i & FieldMask;
  assign issuing     = (state_q == ISSUE);
  assign last_beat   = issuing && (cur_q == mask_q);
  assign out_hs      = issuing && out_ready_i;
  assign in_ready_o  = !issuing || (out_hs && last_beat);
  assign accept      = in_valid_i && in_ready_o;

  // Forcing the non-mask bits to one makes the +1 carry ripple straight across
  // them, so only the don't-care bits count upward.
  assign cur_d = ((cur_q | ~mask_q) + AddrWidth'(1)) & mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      mask_q    <= '0;
      cur_q     <= '0;
      idx_q     <= '0;
      payload_q <= '0;
    end else if (accept) begin
      state_q   <= ISSUE;
      base_q    <= in_addr_i & ~in_mask_eff;
      mask_q    <= in_mask_eff;
      cur_q     <= '0;
      idx_q     <= '0;
      payload_q <= in_payload_i;
    end else if (out_hs) begin
      if (last_beat) begin
        state_q <= IDLE;
      end else begin
        cur_q <= cur_d;
        idx_q <= idx_q + IdxWidth'(1);
      end
    end
  end

  assign out_valid_o   = issuing;
  assign busy_o        = issuing;
  assign out_addr_o    = base_q | cur_q;
  assign out_payload_o = payload_q;
  assign out_last_o    = last_beat;
  assign out_idx_o     = idx_q;

endmodule

// File: doc/picobello_mcast_unroller.md
# picobello_mcast_unroller

Sequential multicast-to-unicast expander for the Picobello FlooNoC mesh. It accepts one request carrying a base address and a multicast mask. The X/Y tile-coordinate fields of the address, at parametrised bit offsets and lengths, are enumerated over every coordinate combination the mask leaves don't-care, and one unicast request per destination is emitted. It sits in front of network-interface ports or target-side adapters that lack native multicast. It generalises the fixed cluster-only X/Y mask encoding to arbitrary field positions, widths and sideband payloads, and adds back-pressured serial issue.

## Interface
- `AddrWidth`, 48: address and mask width.
- `XOffset`, 20: LSB position of the X coordinate field.
- `XLen`, 3: X field width; 0 disables X enumeration.
- `YOffset`, 18: LSB position of the Y coordinate field; fields must not overlap.
- `YLen`, 2: Y field width; 0 disables Y enumeration.
- `PayloadWidth`, 8: width of the opaque sideband forwarded unchanged with every beat.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `in_valid_i`, in, 1: request valid.
- `in_ready_o`, out, 1: request accepted.
- `in_addr_i`, in, AddrWidth: base address.
- `in_mask_i`, in, AddrWidth: multicast mask. A 1 means the bit is don't-care. All-zero means unicast.
- `in_payload_i`, in, PayloadWidth: sideband.
- `out_valid_o`, out, 1: unicast beat valid.
- `out_ready_i`, in, 1: downstream ready.
- `out_addr_o`, out, AddrWidth: unicast destination address.
- `out_payload_o`, out, PayloadWidth: registered copy of `in_payload_i`.
- `out_last_o`, out, 1: final destination of the current request.
- `out_idx_o`, out, XLen+YLen+1: zero-based beat index within the request.
- `busy_o`, out, 1: state is ISSUE.

## Operation
- Effective mask: `m = in_mask_i & F`, where F has ones only in bits [XOffset+:XLen] and [YOffset+:YLen]. Mask bits outside F are ignored.
- States:
  - IDLE: `out_valid_o = 0`, `in_ready_o = 1`.
  - ISSUE: `out_valid_o = 1`.
- Acceptance (`in_valid_i && in_ready_o`):
  - Register `base = in_addr_i & ~m`, the mask `m`, and the payload.
  - Set `cur = 0` and `idx = 0`.
  - Go to ISSUE.
- In ISSUE:
  - `out_addr_o = base | cur`.
  - `out_last_o = (cur == m)`.
  - `out_idx_o = idx`.
- On each output handshake with `out_last_o = 0`:
  - `cur <= ((cur | ~m) + 1) & m`, computed in AddrWidth bits with the carry discarded.
  - `idx <= idx + 1`.
- Enumeration order is ascending integer value of the masked bits, so the lower field (Y by default) varies fastest.
- Beat count is 2^popcount(m). Unicast (m = 0) gives exactly one beat, with `out_last_o = 1` and `out_addr_o = in_addr_i`.
- Handshake on the last beat:
  - If `in_valid_i` is also high: accept the new request in the same cycle and stay in ISSUE with the new registers.
  - Otherwise: go to IDLE.
- `in_ready_o = (state == IDLE) || (out_valid_o && out_ready_i && out_last_o)`.
- AXI-style rules:
  - `out_valid_o` never drops before its handshake.
  - `out_addr_o`, `out_payload_o`, `out_last_o` and `out_idx_o` are stable while `out_valid_o && !out_ready_i`.
  - `in_ready_o` may depend combinationally on `out_ready_i`. `out_valid_o` must not depend on `in_valid_i`.

## Timing
- Reset values: state IDLE; `out_valid_o`, `out_last_o`, `busy_o` = 0; `out_addr_o`, `out_payload_o`, `out_idx_o` = 0; `in_ready_o` = 1.
- Latency: acceptance in cycle t gives the first `out_valid_o` in cycle t+1. With `out_ready_i` held high, a request of N destinations occupies cycles t+1 .. t+N.
- Throughput: one beat per cycle, with no bubble between back-to-back requests.
- Reset asserted mid-request: the in-flight request is dropped. No further beats are issued, and all outputs return to their reset values immediately (asynchronous).
- Back-pressure: `out_ready_i` low freezes `cur`, `idx` and all outputs.

## Test plan
- Unicast: addr 0x0010_0040, mask 0, payload 0x5A -> one beat at cycle t+1 with addr 0x0010_0040, last=1, idx=0, payload 0x5A.
- 2×2 multicast: addr 0x0010_0040, mask 0x0014_0000 -> beats 0x0000_0040, 0x0004_0040, 0x0010_0040, 0x0014_0040 with idx 0..3 and last only on the fourth.
- Back-pressure: same request with `out_ready_i` low for 3 cycles on beat 1 -> addr 0x0004_0040 and idx 1 held stable, `in_ready_o` = 0, no beat skipped or duplicated.
- Out-of-field mask: mask 0xFFFF_FFFF_FFFF with XLen=3, YLen=2 -> 32 beats, addresses differing only in bits [22:18], all other bits equal to addr.
- Back-to-back: second request valid during the last beat of the first -> accepted in the same cycle, and its first beat follows in the next cycle with no IDLE cycle.
- Reset mid-request: assert `rst_ni` low after beat 1 of a 4-beat request -> `out_valid_o` = 0 at once. After release, `in_ready_o` = 1 and the next request starts at idx 0.
